// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_target_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam int SPI_BITS = 8;
    localparam int CNT_W = $clog2(SPI_BITS);
    localparam logic [SPI_BITS-1:0] SPI_FILL_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_target_sync.sv
// Multi-flop synchroniser for one SPI pin, with single-cycle rise/fall strobes
// taken from the synchronised level and its previous value.
module spi_target_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync <= {STAGES{RESET_VAL}};
            prev <= RESET_VAL;
        end else begin
            sync <= {sync[STAGES-2:0], pin};
            prev <= sync[STAGES-1];
        end
    end

    assign level = sync[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, oversampled in the system clock domain.
// Optional sticky error flags are built when SPI_TARGET_ERR_EN is defined.
module spi_target
    import spi_target_pkg::*;
#(
    parameter logic [SPI_BITS-1:0] FILL        = SPI_FILL_DEFAULT,
    parameter int                  SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                spi_sclk,
    input  logic                spi_mosi,
    input  logic                spi_cs_n,
    output logic                spi_miso,
    output logic                spi_miso_oe,
    output logic [SPI_BITS-1:0] rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    input  logic [SPI_BITS-1:0] tx_data,
    input  logic                tx_valid,
    output logic                tx_ready,
    output logic                cs_active,
    output logic                err_ovr,
    output logic                err_udr,
    input  logic                err_clr
);

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_level, mosi_rise_unused, mosi_fall_unused;
    logic cs_level, cs_rise, cs_fall;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .resetn(resetn), .pin(spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .pin(spi_mosi),
        .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    // CS_N idles high so reset must not fabricate a fall strobe.
    spi_target_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
        .clk(clk), .resetn(resetn), .pin(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic                byte_done;
    logic [SPI_BITS-1:0] rx_shift;
    logic [SPI_BITS-1:0] tx_shift;
    logic [SPI_BITS-1:0] tx_hold;

    logic [SPI_BITS-1:0] rx_new;
    logic                shifting;
    logic                byte_complete;
    logic                tx_load;
    logic                ovr_evt;
    logic                udr_evt;

    assign rx_new        = {rx_shift[SPI_BITS-2:0], mosi_level};
    assign shifting      = (state == ACTIVE) && !cs_rise;
    assign byte_complete = shifting && sclk_rise && (bit_cnt == CNT_W'(SPI_BITS - 1));
    assign tx_load       = ((state == IDLE) && cs_fall) || (shifting && sclk_fall && byte_done);
    assign ovr_evt       = byte_complete && rx_valid && !rx_ready;
    assign udr_evt       = tx_load && tx_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_done <= 1'b0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            tx_hold   <= '0;
            tx_ready  <= 1'b1;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            cs_active <= 1'b0;
        end else begin
            cs_active <= ~cs_level;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= ACTIVE;
                        bit_cnt   <= '0;
                        byte_done <= 1'b0;
                        rx_shift  <= '0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        bit_cnt   <= '0;
                        byte_done <= 1'b0;
                        rx_shift  <= '0;
                        tx_shift  <= '0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_new;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(SPI_BITS - 1))
                                byte_done <= 1'b1;
                        end
                        if (sclk_fall) begin
                            byte_done <= 1'b0;
                            if (!byte_done)
                                tx_shift <= {tx_shift[SPI_BITS-2:0], 1'b0};
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (tx_valid && tx_ready) begin
                tx_hold  <= tx_data;
                tx_ready <= 1'b0;
            end

            // An empty holding register sends FILL; a same-cycle write stays queued.
            if (tx_load) begin
                if (!tx_ready) begin
                    tx_shift <= tx_hold;
                    tx_ready <= 1'b1;
                end else begin
                    tx_shift <= FILL;
                end
            end

            if (rx_valid && rx_ready)
                rx_valid <= 1'b0;
            if (byte_complete && (!rx_valid || rx_ready)) begin
                rx_data  <= rx_new;
                rx_valid <= 1'b1;
            end
        end
    end

    assign spi_miso    = tx_shift[SPI_BITS-1];
    assign spi_miso_oe = cs_active;

`ifdef SPI_TARGET_ERR_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_ovr <= 1'b0;
            err_udr <= 1'b0;
        end else begin
            if (ovr_evt)
                err_ovr <= 1'b1;
            else if (err_clr)
                err_ovr <= 1'b0;
            if (udr_evt)
                err_udr <= 1'b1;
            else if (err_clr)
                err_udr <= 1'b0;
        end
    end
`else
    logic err_unused;
    assign err_unused = ^{err_clr, ovr_evt, udr_evt};
    assign err_ovr    = 1'b0;
    assign err_udr    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_target.sv
// Self-checking bench for spi_target: SPI controller stimulus with a
// byte-level reference model of the holding register, receive slot and flags.
module tb_spi_target;

    localparam int         HALF = 12;
    localparam logic [7:0] FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       resetn;
    logic       spi_sclk, spi_mosi, spi_cs_n;
    logic       spi_miso, spi_miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic       cs_active, err_ovr, err_udr, err_clr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit       m_full;
    bit [7:0] m_hold;
    bit       m_rx_valid;
    bit [7:0] m_rx_data;
    bit       m_ovr, m_udr;

    spi_target dut (
        .clk(clk), .resetn(resetn),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .cs_active(cs_active), .err_ovr(err_ovr), .err_udr(err_udr), .err_clr(err_clr)
    );

    always #21 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

    task automatic model_reset();
        m_full = 0; m_hold = 0; m_rx_valid = 0; m_rx_data = 0; m_ovr = 0; m_udr = 0;
    endtask

    task automatic model_load(output logic [7:0] b);
        if (m_full) begin
            b = m_hold;
            m_full = 0;
        end else begin
            b = FILL;
`ifdef SPI_TARGET_ERR_EN
            m_udr = 1;
`endif
        end
    endtask

    task automatic model_rx(input logic [7:0] b, input bit ready);
        if (!m_rx_valid || ready) begin
            m_rx_data  = b;
            m_rx_valid = 1;
        end else begin
`ifdef SPI_TARGET_ERR_EN
            m_ovr = 1;
`endif
        end
    endtask

    task automatic push(input logic [7:0] b);
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++; $display("FAIL push_ready_before: got %b want 1", tx_ready);
        end
        tx_data = b; tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        m_hold = b; m_full = 1;
        checks++;
        if (tx_ready !== 1'b0) begin
            errors++; $display("FAIL push_ready_after: got %b want 0", tx_ready);
        end
    endtask

    task automatic consume();
        rx_ready = 1;
        @(negedge clk);
        rx_ready = 0;
        m_rx_valid = 0;
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL consume: rx_valid got %b want 0", rx_valid);
        end
    endtask

    task automatic clear_flags();
        err_clr = 1;
        @(negedge clk);
        err_clr = 0;
        m_ovr = 0; m_udr = 0;
        checks++;
        if ({err_ovr, err_udr} !== 2'b00) begin
            errors++; $display("FAIL err_clr: got ovr=%b udr=%b want 0 0", err_ovr, err_udr);
        end
    endtask

    // mode 0: plain, 1: check rx_valid latency, 2: pulse rx_ready in the completion cycle
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input int mode, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            mi = {mi[6:0], spi_miso};
            spi_sclk = 1;
            if (i == 7 && mode != 0) begin
                repeat (2) @(negedge clk);
                if (mode == 1) begin
                    checks++;
                    if (rx_valid !== 1'b0) begin
                        errors++; $display("FAIL rx_valid_early: got %b want 0", rx_valid);
                    end
                end else begin
                    rx_ready = 1;
                end
                @(negedge clk);
                if (mode == 2) begin
                    rx_ready = 0;
                end else begin
                    checks++;
                    if (rx_valid !== 1'b1 || rx_data !== mo) begin
                        errors++;
                        $display("FAIL rx_valid_latency: got valid=%b data=%h want 1 %h", rx_valid, rx_data, mo);
                    end
                end
                repeat (HALF - 3) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            spi_sclk = 0;
        end
    endtask

    task automatic cs_begin(output logic [7:0] exp_tx);
        spi_cs_n = 0;
        repeat (5) @(negedge clk);
        model_load(exp_tx);
        checks++;
        if (cs_active !== 1'b1 || spi_miso_oe !== 1'b1 || tx_ready !== !m_full) begin
            errors++;
            $display("FAIL cs_begin: cs_active=%b oe=%b tx_ready=%b want 1 1 %b", cs_active, spi_miso_oe, tx_ready, !m_full);
        end
    endtask

    task automatic cs_end();
        spi_cs_n = 1;
        repeat (6) @(negedge clk);
        checks++;
        if (cs_active !== 1'b0 || spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL cs_end: cs_active=%b oe=%b miso=%b want 0 0 0", cs_active, spi_miso_oe, spi_miso);
        end
    endtask

    task automatic xfer(input int n, input logic [23:0] mo_v, input int mode, input bit rand_gaps);
        logic [7:0] exp_tx, mi, mo;
        cs_begin(exp_tx);
        for (int k = 0; k < n; k++) begin
            mo = mo_v[23-8*k -: 8];
            spi_bits(mo, 8, (k == n - 1) ? mode : 0, mi);
            checks++;
            if (mi !== exp_tx) begin
                errors++; $display("FAIL miso_byte%0d: got %h want %h", k, mi, exp_tx);
            end
            model_rx(mo, (k == n - 1) && (mode == 2));
            repeat (4) @(negedge clk);
            model_load(exp_tx);
            checks++;
            if (rx_valid !== m_rx_valid || rx_data !== m_rx_data || tx_ready !== !m_full ||
                err_ovr !== m_ovr || err_udr !== m_udr) begin
                errors++;
                $display("FAIL byte_state%0d: got v=%b d=%h tr=%b ovr=%b udr=%b want %b %h %b %b %b", k,
                         rx_valid, rx_data, tx_ready, err_ovr, err_udr,
                         m_rx_valid, m_rx_data, !m_full, m_ovr, m_udr);
            end
            if (rand_gaps) begin
                if (!m_full && $urandom_range(0, 1) == 1) push(8'($urandom));
                if (m_rx_valid && $urandom_range(0, 1) == 1) consume();
            end
        end
        cs_end();
    endtask

    task automatic test_reset();
        logic [7:0] exp_tx, mi;
        resetn = 0; spi_sclk = 0; spi_mosi = 0; spi_cs_n = 1;
        rx_ready = 0; tx_valid = 0; tx_data = 0; err_clr = 0;
        model_reset();
        repeat (3) @(negedge clk);
        resetn = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (rx_valid !== 0 || rx_data !== 8'h00 || tx_ready !== 1 || cs_active !== 0 ||
            spi_miso !== 0 || spi_miso_oe !== 0 || err_ovr !== 0 || err_udr !== 0) begin
            errors++; $display("FAIL reset_values: rxv=%b rxd=%h txr=%b cs=%b miso=%b oe=%b ovr=%b udr=%b",
                               rx_valid, rx_data, tx_ready, cs_active, spi_miso, spi_miso_oe, err_ovr, err_udr);
        end
        // Reset in the middle of an active transfer
        push(8'h5A);
        cs_begin(exp_tx);
        push(8'h77);
        spi_bits(8'hC3, 8, 0, mi);
        model_rx(8'hC3, 0);
        spi_bits(8'h0F, 3, 0, mi);
        #3 resetn = 0;
        #1;
        checks++;
        if (rx_valid !== 0 || rx_data !== 8'h00 || tx_ready !== 1 || cs_active !== 0 ||
            spi_miso !== 0 || spi_miso_oe !== 0 || err_ovr !== 0 || err_udr !== 0) begin
            errors++; $display("FAIL reset_mid: rxv=%b rxd=%h txr=%b cs=%b miso=%b oe=%b ovr=%b udr=%b",
                               rx_valid, rx_data, tx_ready, cs_active, spi_miso, spi_miso_oe, err_ovr, err_udr);
        end
        spi_cs_n = 1; spi_sclk = 0; spi_mosi = 0;
        model_reset();
        repeat (4) @(negedge clk);
        resetn = 1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] t, r;
        push(8'hA5);
        xfer(1, {8'h3C, 16'h0}, 1, 0);
        checks++;
        if (rx_data !== 8'h3C) begin
            errors++; $display("FAIL basic_rx: got %h want 3c", rx_data);
        end
        for (int i = 0; i < 3; i++) begin
            if (m_rx_valid) consume();
            t = 8'($urandom); r = 8'($urandom);
            push(t);
            xfer(1, {r, 16'h0}, 1, 0);
        end
    endtask

    task automatic test_underrun_overrun();
        logic [23:0] v;
        if (m_rx_valid) consume();
        clear_flags();
        v = 24'($urandom);
        xfer(3, v, 0, 0);
        checks++;
        if (rx_data !== v[23:16] || rx_valid !== 1) begin
            errors++; $display("FAIL ovr_holds_first: got %h valid=%b want %h 1", rx_data, rx_valid, v[23:16]);
        end
        checks++;
`ifdef SPI_TARGET_ERR_EN
        if (err_ovr !== 1 || err_udr !== 1) begin
            errors++; $display("FAIL err_flags_set: got ovr=%b udr=%b want 1 1", err_ovr, err_udr);
        end
`else
        if (err_ovr !== 0 || err_udr !== 0) begin
            errors++; $display("FAIL err_flags_tied: got ovr=%b udr=%b want 0 0", err_ovr, err_udr);
        end
`endif
        clear_flags();
    endtask

    task automatic test_partial();
        logic [7:0] exp_tx, mi;
        if (m_rx_valid) consume();
        push(8'($urandom));
        cs_begin(exp_tx);
        spi_bits(8'($urandom), 5, 0, mi);
        checks++;
        if (mi[4:0] !== exp_tx[7:3]) begin
            errors++; $display("FAIL partial_miso: got %b want %b", mi[4:0], exp_tx[7:3]);
        end
        cs_end();
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++; $display("FAIL partial_no_valid: got %b want 0", rx_valid);
        end
        xfer(1, {8'h81, 16'h0}, 1, 0);
        checks++;
        if (rx_data !== 8'h81) begin
            errors++; $display("FAIL after_partial: got %h want 81", rx_data);
        end
    endtask

    task automatic test_ready_same_cycle();
        logic [7:0] a, b;
        if (m_rx_valid) consume();
        clear_flags();
        a = 8'($urandom); b = ~a;
        xfer(2, {a, b, 8'h0}, 2, 0);
        checks++;
        if (rx_valid !== 1 || rx_data !== b || err_ovr !== 0) begin
            errors++; $display("FAIL ready_same_cycle: got v=%b d=%h ovr=%b want 1 %h 0", rx_valid, rx_data, err_ovr, b);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            if (m_rx_valid && $urandom_range(0, 1) == 1) consume();
            if (!m_full && $urandom_range(0, 1) == 1) push(8'($urandom));
            if ($urandom_range(0, 3) == 0) clear_flags();
            xfer(int'($urandom_range(1, 3)), 24'($urandom), 0, 1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun_overrun();
        test_partial();
        test_ready_same_cycle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
